// File: rtl/jtkunio_pkg.sv
// jtkunio_pkg: shared MCU port bit positions for the Kunio protection interface
package jtkunio_pkg;
   localparam int PB_RD_N      = 1;
   localparam int PB_WR_N      = 2;
   localparam int PC_M2S_FULL  = 0;
   localparam int PC_S2M_NFULL = 1;
   localparam int PC_OVR       = 7;
endpackage

// File: rtl/jtkunio_mbox_latch.sv
// jtkunio_mbox_latch: one-direction mailbox byte with full flag and overrun pulse
module jtkunio_mbox_latch (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr,
   input  logic       rd,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       ovr_p
);
   always_ff @(posedge clk, posedge rst)
      if (rst) begin
         dout <= '0;
         full <= 1'b0;
      end else begin
         if (wr) dout <= din;
         if (wr | rd) full <= wr;
      end
   // a read in the same cycle consumed the old byte, so it is not an overrun
   assign ovr_p = wr & full & ~rd;
endmodule

// File: rtl/jtkunio_mcu_mbox.sv
// jtkunio_mcu_mbox: main 6502 <-> 68705 mailbox with status bits and MCU interrupt
module jtkunio_mcu_mbox
   import jtkunio_pkg::*;
#(
   parameter bit MAIN_ST_INV = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       main_cs,
   input  logic       main_rnw,
   input  logic [7:0] main_din,
   output logic [7:0] main_dout,
   output logic [1:0] mcu_st,
   input  logic [7:0] mcu_pa_out,
   output logic [7:0] mcu_pa_in,
   input  logic [7:0] mcu_pb_out,
   output logic [7:0] mcu_pc_in,
   output logic       mcu_irqn
);
   logic main_cs_l, rd_n_l, wr_n_l;
   logic rd_n, wr_n, cs_rise, main_wr, main_rd, mcu_rd, mcu_wr;
   logic m2s_full, s2m_full, m2s_ovr, s2m_ovr, ovr;
   logic unused_pb;

   assign rd_n      = mcu_pb_out[PB_RD_N];
   assign wr_n      = mcu_pb_out[PB_WR_N];
   assign unused_pb = ^{mcu_pb_out[7:3], mcu_pb_out[0]};

   // edge registers reset to the idle level so a held strobe counts after reset
   always_ff @(posedge clk, posedge rst)
      if (rst) begin
         main_cs_l <= 1'b0;
         rd_n_l    <= 1'b1;
         wr_n_l    <= 1'b1;
         ovr       <= 1'b0;
      end else begin
         main_cs_l <= main_cs;
         rd_n_l    <= rd_n;
         wr_n_l    <= wr_n;
         ovr       <= ovr | m2s_ovr | s2m_ovr;
      end

   assign cs_rise = main_cs & ~main_cs_l;
   assign main_wr = cs_rise & ~main_rnw;
   assign main_rd = cs_rise & main_rnw;
   assign mcu_rd  = rd_n_l & ~rd_n;
   assign mcu_wr  = wr_n_l & ~wr_n;

   jtkunio_mbox_latch u_m2s (
      .clk(clk), .rst(rst), .wr(main_wr), .rd(mcu_rd), .din(main_din),
      .dout(mcu_pa_in), .full(m2s_full), .ovr_p(m2s_ovr)
   );

   jtkunio_mbox_latch u_s2m (
      .clk(clk), .rst(rst), .wr(mcu_wr), .rd(main_rd), .din(mcu_pa_out),
      .dout(main_dout), .full(s2m_full), .ovr_p(s2m_ovr)
   );

   assign mcu_st   = {s2m_full, m2s_full} ^ {2{MAIN_ST_INV}};
   assign mcu_irqn = ~m2s_full;

   always_comb begin
      mcu_pc_in               = '0;
      mcu_pc_in[PC_M2S_FULL]  = m2s_full;
      mcu_pc_in[PC_S2M_NFULL] = ~s2m_full;
      mcu_pc_in[PC_OVR]       = ovr;
   end
endmodule

// File: tb/tb_jtkunio_mcu_mbox.sv
// tb_jtkunio_mcu_mbox: randomized mailbox transactions against a transaction-level model
module tb_jtkunio_mcu_mbox;
   logic       clk = 1'b0;
   logic       rst;
   logic       main_cs, main_rnw;
   logic [7:0] main_din, mcu_pa_out, mcu_pb_out;
   logic [7:0] main_dout, mcu_pa_in, mcu_pc_in;
   logic [7:0] main_dout_i, mcu_pa_in_i, mcu_pc_in_i;
   logic [1:0] mcu_st, mcu_st_i;
   logic       mcu_irqn, mcu_irqn_i;

   int checks = 0;
   int errors = 0;

   // reference mailbox state
   logic [7:0] m2s, s2m;
   logic       mf, sf, ov;

   always #5 clk = ~clk;

   jtkunio_mcu_mbox #(.MAIN_ST_INV(1'b0)) dut (
      .clk(clk), .rst(rst), .main_cs(main_cs), .main_rnw(main_rnw), .main_din(main_din),
      .main_dout(main_dout), .mcu_st(mcu_st), .mcu_pa_out(mcu_pa_out), .mcu_pa_in(mcu_pa_in),
      .mcu_pb_out(mcu_pb_out), .mcu_pc_in(mcu_pc_in), .mcu_irqn(mcu_irqn)
   );

   jtkunio_mcu_mbox #(.MAIN_ST_INV(1'b1)) dut_inv (
      .clk(clk), .rst(rst), .main_cs(main_cs), .main_rnw(main_rnw), .main_din(main_din),
      .main_dout(main_dout_i), .mcu_st(mcu_st_i), .mcu_pa_out(mcu_pa_out), .mcu_pa_in(mcu_pa_in_i),
      .mcu_pb_out(mcu_pb_out), .mcu_pc_in(mcu_pc_in_i), .mcu_irqn(mcu_irqn_i)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":main_dout"}, main_dout, s2m);
      chk({tag, ":mcu_pa_in"}, mcu_pa_in, m2s);
      chk({tag, ":mcu_st"}, {6'd0, mcu_st}, {6'd0, sf, mf});
      chk({tag, ":mcu_st_inv"}, {6'd0, mcu_st_i}, {6'd0, ~sf, ~mf});
      chk({tag, ":mcu_pc_in"}, mcu_pc_in, {ov, 5'd0, ~sf, mf});
      chk({tag, ":mcu_irqn"}, {7'd0, mcu_irqn}, {7'd0, ~mf});
   endtask

   task automatic model_reset();
      m2s = 8'h00; s2m = 8'h00; mf = 1'b0; sf = 1'b0; ov = 1'b0;
   endtask

   // one strobe edge of each requested kind; a write beats a same-cycle read
   task automatic model_apply(input bit mw, input bit mr, input bit sr, input bit sw,
                              input logic [7:0] md, input logic [7:0] sd);
      if (sr) mf = 1'b0;
      if (mw) begin
         if (mf) ov = 1'b1;
         m2s = md;
         mf  = 1'b1;
      end
      if (mr) sf = 1'b0;
      if (sw) begin
         if (sf) ov = 1'b1;
         s2m = sd;
         sf  = 1'b1;
      end
   endtask

   task automatic drive(input bit mw, input bit mr, input bit sr, input bit sw,
                        input logic [7:0] md, input logic [7:0] sd);
      main_cs       = mw | mr;
      main_rnw      = ~mw;
      main_din      = md;
      mcu_pa_out    = sd;
      mcu_pb_out    = 8'($urandom);
      mcu_pb_out[1] = ~sr;
      mcu_pb_out[2] = ~sw;
   endtask

   task automatic release_all();
      main_cs       = 1'b0;
      mcu_pb_out    = 8'($urandom);
      mcu_pb_out[1] = 1'b1;
      mcu_pb_out[2] = 1'b1;
   endtask

   task automatic do_op(input string tag, input bit mw, input bit mr, input bit sr, input bit sw,
                        input logic [7:0] md, input logic [7:0] sd, input int hold);
      @(negedge clk);
      drive(mw, mr, sr, sw, md, sd);
      @(posedge clk);
      model_apply(mw, mr, sr, sw, md, sd);
      repeat (hold) @(negedge clk);
      check_all({tag, "/held"});
      release_all();
      @(negedge clk);
      check_all({tag, "/idle"});
   endtask

   initial begin
      rst = 1'b1;
      main_cs = 1'b0; main_rnw = 1'b1; main_din = 8'h00;
      mcu_pa_out = 8'h00; mcu_pb_out = 8'hFF;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all("reset");

      do_op("main_wr_a5", 1, 0, 0, 0, 8'hA5, 8'h00, 4);
      do_op("mcu_rd_long", 0, 0, 1, 0, 8'h00, 8'h00, 10);
      do_op("mcu_wr_3c", 0, 0, 0, 1, 8'h00, 8'h3C, 2);
      do_op("main_rd", 0, 1, 0, 0, 8'h00, 8'h00, 4);
      do_op("main_wr_11", 1, 0, 0, 0, 8'h11, 8'h00, 3);
      do_op("main_wr_22", 1, 0, 0, 0, 8'h22, 8'h00, 3);
      do_op("mcu_rd_ovr", 0, 0, 1, 0, 8'h00, 8'h00, 2);
      do_op("main_rd_ovr", 0, 1, 0, 0, 8'h00, 8'h00, 2);

      // same-cycle write/read collisions, clean overrun state first
      rst = 1'b1; model_reset();
      @(negedge clk); rst = 1'b0;
      do_op("prefill", 1, 0, 0, 0, 8'h10, 8'h00, 2);
      do_op("wr77_rd", 1, 0, 1, 0, 8'h77, 8'h00, 3);
      do_op("prefill_s", 0, 0, 0, 1, 8'h00, 8'h44, 2);
      do_op("all4", 1, 0, 1, 1, 8'h99, 8'h55, 3);
      do_op("mcuwr_mainrd", 0, 1, 0, 1, 8'h00, 8'h66, 3);

      // asynchronous reset mid-strobe, strobe held across release
      @(negedge clk);
      drive(0, 0, 0, 1, 8'h00, 8'h5A);
      @(posedge clk);
      model_apply(0, 0, 0, 1, 8'h00, 8'h5A);
      @(negedge clk);
      check_all("pre_rst");
      #2 rst = 1'b1;
      #1 model_reset();
      check_all("async_rst");
      @(negedge clk); rst = 1'b0;
      @(posedge clk);
      model_apply(0, 0, 0, 1, 8'h00, 8'h5A);
      @(negedge clk);
      check_all("held_after_rst");
      release_all();
      @(negedge clk);
      check_all("post_rst_idle");

      for (int i = 0; i < 300; i++) begin
         int mop;
         bit sr, sw;
         mop = int'($urandom_range(0, 2));
         sr  = 1'($urandom);
         sw  = 1'($urandom);
         if (mop == 0 && !sr && !sw) sw = 1'b1;
         do_op("rand", mop == 1, mop == 2, sr, sw, 8'($urandom), 8'($urandom),
               int'($urandom_range(1, 6)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
